// File: rtl/data_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_responder_pkg
//   Shared definitions for the data-RAM responder slice: FSM state encoding,
//   default storage geometry, request bus field widths and counter width.
//   Optional feature macro used by the files importing this package:
//     DATA_RAM_WAIT_EN - compiles in the WAIT state and its delay counter.
// -----------------------------------------------------------------------------
package data_ram_responder_pkg;

    // Responder FSM encoding (2 bits, exported on the debug state port).
    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_RESP = 2'd2
    } dram_state_e;

    // Default word-index width: 2^10 words of 32 bits.
    localparam int DATA_RAM_ADDR_W = 10;

    // Widths of the EXE->MEM request bus fields.
    localparam int REQ_WEN_W  = 4;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
    localparam int DRAM_CNT_W = 4;

endpackage

// File: rtl/data_ram_array.sv
// -----------------------------------------------------------------------------
// data_ram_array
//   Single-port 2^ADDR_W x 32 storage with four byte-write enables and a
//   synchronous, registered read. Contents and read register are not reset.
//   Ports:
//     clk_i    - clock
//     en_i     - access enable for this cycle
//     we_i     - byte write enables; all-zero with en_i set performs a read
//     addr_i   - word index
//     wdata_i  - write data, lane i = wdata_i[8i+7:8i]
//     rdata_o  - read data, updated only by a read access
// -----------------------------------------------------------------------------
module data_ram_array
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W = DATA_RAM_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [REQ_WEN_W-1:0]  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [REQ_DATA_W-1:0] wdata_i,
    output logic [REQ_DATA_W-1:0] rdata_o
);

    logic [REQ_DATA_W-1:0] mem_q [2**ADDR_W];
    logic [REQ_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < REQ_WEN_W; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            // Read register only moves on a read, so a held response is stable.
            if (we_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//   Responder end of the data-RAM interface: accepts one load/store request at
//   a time from EXE, owns the word storage and returns the load word to MEM.
//   Optional macro: DATA_RAM_WAIT_EN adds WAIT_CYCLES extra response delay.
//   Ports:
//     clk, resetn            - clock, asynchronous active-low reset
//     req_valid / req_ready  - request handshake (from EXE)
//     req_wen                - byte enables, 0 = load, else store
//     req_addr               - byte address, bits [ADDR_W+1:2] select the word
//     req_wdata              - store data
//     resp_valid / resp_ready- response handshake (to MEM)
//     data_ram_r_data        - loaded word, zero for store responses
//     dbg_state              - current FSM state
//
//   Handshake: a transfer happens on a rising edge where valid & ready are both
//   high; a valid side holds its payload until that edge; ready may depend
//   combinationally on the opposite side's ready (req_ready follows resp_ready
//   in RESP), never on valid.
// -----------------------------------------------------------------------------
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W      = DATA_RAM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REQ_WEN_W-1:0]  req_wen,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [REQ_DATA_W-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [REQ_DATA_W-1:0] data_ram_r_data,
    output logic [1:0]            dbg_state
);

    dram_state_e state_q, state_d;
    logic        is_load_q, is_load_d;
    logic        accept;
    logic [REQ_DATA_W-1:0] ram_rdata;

`ifdef DATA_RAM_WAIT_EN
    localparam logic [DRAM_CNT_W-1:0] WAIT_LOAD =
        4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    localparam bit USE_WAIT = (WAIT_CYCLES != 0);
    logic [DRAM_CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [DRAM_CNT_W-1:0] unused_wait_cycles;
    assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

    // Address bits outside the word index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[REQ_ADDR_W-1:ADDR_W+2], req_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
`ifdef DATA_RAM_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            DRAM_IDLE: req_ready = 1'b1;
`ifdef DATA_RAM_WAIT_EN
            DRAM_WAIT: begin
                if (cnt_q == '0) state_d = DRAM_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            DRAM_RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready) state_d = DRAM_IDLE;
            end
            default: state_d = DRAM_IDLE;
        endcase

        accept = req_valid & req_ready;
        // A new acceptance overrides the RESP->IDLE exit above.
        if (accept) begin
            is_load_d = (req_wen == '0);
`ifdef DATA_RAM_WAIT_EN
            if (USE_WAIT) begin
                state_d = DRAM_WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = DRAM_RESP;
            end
`else
            state_d = DRAM_RESP;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DRAM_IDLE;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

`ifdef DATA_RAM_WAIT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    // Loads leave req_wen at zero toward the array so they never write.
    data_ram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk_i   (clk),
        .en_i    (accept),
        .we_i    ((req_wen == '0) ? '0 : req_wen),
        .addr_i  (req_addr[ADDR_W+1:2]),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    // Store responses and the post-reset value read as zero.
    assign data_ram_r_data = is_load_q ? ram_rdata : '0;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
`ifdef DATA_RAM_WAIT_EN
    localparam int LAT = 1 + WAIT_CYCLES;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_wen = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] data_ram_r_data;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wen         (req_wen),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .data_ram_r_data (data_ram_r_data),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_at = 0;
    logic [31:0] mem_m [int];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic step(input logic v, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rr,
                        output bit got_ready, output bit got_valid);
        bit vexp, rexp;
        int idx;
        logic [31:0] w;
        @(negedge clk);
        req_valid = v; req_wen = wen; req_addr = addr; req_wdata = wdata; resp_ready = rr;
        #1;
        vexp = (exp_q.size() != 0) && (cyc >= ready_at);
        rexp = (exp_q.size() == 0) || (vexp && rr);
        got_ready = req_ready;
        got_valid = resp_valid;
        check("resp_valid", {31'b0, resp_valid}, {31'b0, vexp});
        check("req_ready", {31'b0, req_ready}, {31'b0, rexp});
        if (vexp) check("r_data", data_ram_r_data, exp_q[0]);
        @(posedge clk);
        cyc++;
        if (vexp && rr) void'(exp_q.pop_front());
        if (v && rexp) begin
            idx = word_of(addr);
            if (wen == 4'h0) begin
                exp_q.push_back(mem_m[idx]);
            end else begin
                w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
                mem_m[idx] = w;
                exp_q.push_back(32'h0);
            end
            ready_at = cyc + LAT - 1;
        end
    endtask

    // Full transaction with resp_ready high: wait for acceptance, then response.
    task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bit rdy, vld, seen;
        int n;
        rdy = 0; n = 0;
        while (!rdy && n < 20) begin
            step(1'b1, wen, addr, wdata, 1'b1, rdy, vld);
            n++;
        end
        check("accept_timeout", {31'b0, rdy}, 32'd1);
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rdy, vld);
            seen = vld;
            n++;
        end
        check("resp_timeout", {31'b0, seen}, 32'd1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_r_data", data_ram_r_data, 32'h0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rdy, vld, held;
        logic v, rr;
        logic [3:0] wen;
        logic [31:0] addr, wdata;
        int idx;

        // reset state
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_r_data", data_ram_r_data, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'($urandom_range(0, 1)), rdy, vld);
            #1 check("idle_r_data", data_ram_r_data, 32'h0);
        end

        // store then load
        txn(4'hF, 32'h10, 32'hDEADBEEF);
        txn(4'h0, 32'h10, 32'h0);

        // byte lanes
        txn(4'hF, 32'h20, 32'h11223344);
        txn(4'b0101, 32'h20, 32'hAABBCCDD);
        txn(4'h0, 32'h22, 32'h0);

        // backpressure: held load response, blocked request, then same-cycle handoff
        step(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, rdy, vld);
        for (int i = 0; i < LAT + 4; i++)
            step(1'b1, 4'hF, 32'h30, 32'h55667788, 1'b0, rdy, vld);
        step(1'b1, 4'hF, 32'h30, 32'h55667788, 1'b1, rdy, vld);
        check("handoff_accept", {31'b0, rdy}, 32'd1);
        for (int i = 0; i < LAT + 1; i++)
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rdy, vld);

        // back-to-back loads with resp_ready held high
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'h0, (i % 2 == 0) ? 32'h10 : 32'h30, 32'h0, 1'b1, rdy, vld);
        for (int i = 0; i < LAT + 1; i++)
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rdy, vld);

        // index wrap
        txn(4'hF, 32'h1000, 32'hCAFEF00D);
        txn(4'h0, 32'h0, 32'h0);
        txn(4'h0, 32'hFFFFF003, 32'h0);

        // reset with a load pending; earlier stores must survive
        step(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, rdy, vld);
        reset_mid();
        txn(4'h0, 32'h10, 32'h0);
        txn(4'h0, 32'h20, 32'h0);

        // randomized traffic
        held = 0; v = 0; rr = 0; wen = 0; addr = 0; wdata = 0;
        for (int i = 0; i < 500; i++) begin
            if (!held) begin
                v = ($urandom_range(0, 3) != 0);
                idx = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1)
                                                  : $urandom_range(0, 15);
                addr = ($urandom() << (ADDR_W + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
                wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                if (wen == 4'h0 && !mem_m.exists(idx)) wen = 4'hF;
                wdata = $urandom();
            end
            rr = ($urandom_range(0, 3) != 0);
            step(v, wen, addr, wdata, rr, rdy, vld);
            held = v && !rdy;
        end
        for (int i = 0; i < LAT + 2; i++)
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rdy, vld);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
